// File: rtl/sub2_stage.sv
// Two-stage WIDTH-bit subtractor (lo half in stage 1, hi half in stage 2) with borrow out.
// Latency 2 cycles, 1 result/cycle; in_ready = !s1_valid || !s2_valid || out_ready, no skid buffer.
// Stalls hold both stages; optional signed overflow output enabled by define SUB2_STAGE_OVF_EN.
module sub2_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow
`ifdef SUB2_STAGE_OVF_EN
    ,
    output logic             out_overflow
`endif
);
    localparam int LO = WIDTH / 2;
    localparam int HI = WIDTH - LO;

    logic             s1_valid;
    logic [LO-1:0]    s1_diff_lo;
    logic             s1_borrow_lo;
    logic [HI-1:0]    s1_a_hi;
    logic [HI-1:0]    s1_b_hi;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_diff;
    logic             s2_borrow;

    logic             adv1;
    logic             adv2;
    logic [LO:0]      lo_ext;
    logic [HI:0]      hi_ext;

    assign adv2 = !s2_valid || out_ready;
    assign adv1 = !s1_valid || adv2;
    // Gated by reset so upstream sees not-ready while the pipe is held cleared.
    assign in_ready = adv1 && reset;

    // Extra top bit of each widened subtraction is the borrow out of that half.
    assign lo_ext = {1'b0, in_1[LO-1:0]} - {1'b0, in_2[LO-1:0]};
    assign hi_ext = {1'b0, s1_a_hi} - {1'b0, s1_b_hi} - {{HI{1'b0}}, s1_borrow_lo};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid     <= 1'b0;
            s1_diff_lo   <= '0;
            s1_borrow_lo <= 1'b0;
            s1_a_hi      <= '0;
            s1_b_hi      <= '0;
        end else if (adv1) begin
            s1_valid     <= in_valid;
            s1_diff_lo   <= lo_ext[LO-1:0];
            s1_borrow_lo <= lo_ext[LO];
            s1_a_hi      <= in_1[WIDTH-1:LO];
            s1_b_hi      <= in_2[WIDTH-1:LO];
        end
    end

`ifdef SUB2_STAGE_OVF_EN
    logic s2_overflow;
    logic ovf_next;

    assign ovf_next = (s1_a_hi[HI-1] != s1_b_hi[HI-1]) && (hi_ext[HI-1] != s1_a_hi[HI-1]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s2_overflow <= 1'b0;
        end else if (adv2) begin
            s2_overflow <= ovf_next;
        end
    end

    assign out_overflow = s2_overflow;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s2_valid  <= 1'b0;
            s2_diff   <= '0;
            s2_borrow <= 1'b0;
        end else if (adv2) begin
            s2_valid  <= s1_valid;
            s2_diff   <= {hi_ext[HI-1:0], s1_diff_lo};
            s2_borrow <= hi_ext[HI];
        end
    end

    assign out_valid  = s2_valid;
    assign out_diff   = s2_diff;
    assign out_borrow = s2_borrow;
endmodule

// File: tb/tb_sub2_stage.sv
// Directed bench for sub2_stage: reset, arithmetic corners, streaming, backpressure, mid-flight reset.
module tb_sub2_stage;
    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_1;
    logic [31:0] in_2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_diff;
    logic        out_borrow;
    logic        out_overflow;

    int checks = 0;
    int errors = 0;

    sub2_stage #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_1       (in_1),
        .in_2       (in_2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_diff   (out_diff),
`ifdef SUB2_STAGE_OVF_EN
        .out_borrow (out_borrow),
        .out_overflow(out_overflow)
`else
        .out_borrow (out_borrow)
`endif
    );

`ifndef SUB2_STAGE_OVF_EN
    assign out_overflow = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_diff !== 32'h0) begin errors++; $display("FAIL reset_diff got %h want 0", out_diff); end
        checks++; if (out_borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b want 0", out_borrow); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        in_valid = 1'b1; in_1 = 32'd77; in_2 = 32'd11;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_held_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_held_in_ready got %b want 0", in_ready); end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_valid got %b want 0", out_valid); end
    endtask

    task automatic test_basic();
        in_valid = 1'b1; in_1 = 32'd9273; in_2 = 32'd3827;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", out_valid); end
        checks++; if (out_diff !== 32'd5446) begin errors++; $display("FAIL basic_diff got %0d want 5446", out_diff); end
        checks++; if (out_borrow !== 1'b0) begin errors++; $display("FAIL basic_borrow got %b want 0", out_borrow); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got %b want 0", out_valid); end
    endtask

    task automatic test_borrow_chain();
        logic [31:0] a [3] = '{32'h0001_0000, 32'h0000_0000, 32'hFFFF_0000};
        logic [31:0] b [3] = '{32'h0000_0001, 32'h0000_0001, 32'hFFFF_0000};
        logic [31:0] d [3] = '{32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        logic        br [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL chain_valid[%0d] got %b want 1", i-2, out_valid); end
                checks++; if (out_diff !== d[i-2]) begin errors++; $display("FAIL chain_diff[%0d] got %h want %h", i-2, out_diff, d[i-2]); end
                checks++; if (out_borrow !== br[i-2]) begin errors++; $display("FAIL chain_borrow[%0d] got %b want %b", i-2, out_borrow, br[i-2]); end
            end
            if (i < 3) begin in_valid = 1'b1; in_1 = a[i]; in_2 = b[i]; end
            else in_valid = 1'b0;
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL chain_drained got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [3] = '{32'd200, 32'd13442, 32'd0};
        logic [31:0] b [3] = '{32'd100, 32'd10042, 32'd9253};
        logic [31:0] d [3] = '{32'd100, 32'd3400, 32'hFFFF_DBDB};
        logic        br [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready); end
            if (i >= 2) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b want 1", i-2, out_valid); end
                checks++; if (out_diff !== d[i-2]) begin errors++; $display("FAIL b2b_diff[%0d] got %h want %h", i-2, out_diff, d[i-2]); end
                checks++; if (out_borrow !== br[i-2]) begin errors++; $display("FAIL b2b_borrow[%0d] got %b want %b", i-2, out_borrow, br[i-2]); end
            end
            if (i < 3) begin in_valid = 1'b1; in_1 = a[i]; in_2 = b[i]; end
            else in_valid = 1'b0;
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] a [4] = '{32'd1000, 32'd5, 32'h1234_5678, 32'd77};
        logic [31:0] b [4] = '{32'd1, 32'd7, 32'h0234_5678, 32'd77};
        logic [31:0] d [4] = '{32'd999, 32'hFFFF_FFFE, 32'h1000_0000, 32'd0};
        logic        br [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        int idx = 0;
        int got = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_1 = a[idx]; in_2 = b[idx];
            #1;
            checks++; if (in_ready !== (c < 2)) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want %b", c, in_ready, (c < 2)); end
            if (c >= 2) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid[%0d] got %b want 1", c, out_valid); end
                checks++; if (out_diff !== d[0]) begin errors++; $display("FAIL bp_stall_diff[%0d] got %h want %h", c, out_diff, d[0]); end
            end
            if (in_ready) idx++;
            tick();
        end
        checks++; if (idx !== 2) begin errors++; $display("FAIL bp_accepts got %0d want 2", idx); end
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (idx < 4) begin in_valid = 1'b1; in_1 = a[idx]; in_2 = b[idx]; end
            else in_valid = 1'b0;
            #1;
            if (c == 0) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_full_pop_in_ready got %b want 1", in_ready); end
            end
            if (out_valid) begin
                checks++;
                if (got >= 4) begin errors++; $display("FAIL bp_extra_result got %h want none", out_diff); end
                else if (out_diff !== d[got] || out_borrow !== br[got]) begin
                    errors++; $display("FAIL bp_result[%0d] got %h/%b want %h/%b", got, out_diff, out_borrow, d[got], br[got]);
                end
                got++;
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (got !== 4) begin errors++; $display("FAIL bp_result_count got %0d want 4", got); end
    endtask

    task automatic test_reset_mid_flight();
        out_ready = 1'b0;
        in_valid = 1'b1; in_1 = 32'd50; in_2 = 32'd8;
        tick();
        in_1 = 32'd3; in_2 = 32'd9;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmf_loaded_valid got %b want 1", out_valid); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmf_valid got %b want 0", out_valid); end
        checks++; if (out_diff !== 32'h0) begin errors++; $display("FAIL rmf_diff got %h want 0", out_diff); end
        checks++; if (out_borrow !== 1'b0) begin errors++; $display("FAIL rmf_borrow got %b want 0", out_borrow); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmf_in_ready got %b want 0", in_ready); end
`ifdef SUB2_STAGE_OVF_EN
        checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL rmf_overflow got %b want 0", out_overflow); end
`endif
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmf_release_in_ready got %b want 1", in_ready); end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmf_stale[%0d] got %b want 0", c, out_valid); end
        end
    endtask

`ifdef SUB2_STAGE_OVF_EN
    task automatic test_overflow();
        logic [31:0] a [3] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd5};
        logic [31:0] b [3] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'd3};
        logic [31:0] d [3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd2};
        logic        br [3] = '{1'b0, 1'b1, 1'b0};
        logic        ov [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) begin
                checks++; if (out_diff !== d[i-2]) begin errors++; $display("FAIL ovf_diff[%0d] got %h want %h", i-2, out_diff, d[i-2]); end
                checks++; if (out_borrow !== br[i-2]) begin errors++; $display("FAIL ovf_borrow[%0d] got %b want %b", i-2, out_borrow, br[i-2]); end
                checks++; if (out_overflow !== ov[i-2]) begin errors++; $display("FAIL ovf_flag[%0d] got %b want %b", i-2, out_overflow, ov[i-2]); end
            end
            if (i < 3) begin in_valid = 1'b1; in_1 = a[i]; in_2 = b[i]; end
            else in_valid = 1'b0;
            tick();
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        in_1 = '0;
        in_2 = '0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_borrow_chain();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_flight();
`ifdef SUB2_STAGE_OVF_EN
        test_overflow();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sub2_stage.md
Name: sub2_stage

Overview:
- 2-stage pipelined WIDTH-bit subtractor with borrow out.
- Inverse-operation companion to the 2-stage adder. Same lo-half/hi-half split, so the carry/borrow chain is cut at WIDTH/2.
- Adds valid/ready handshakes on both sides so it can sit in a stalling datapath.
- Used downstream of the adder for checking (sum - in_2 == in_1) and as a standalone arithmetic stage.

Parameters:
- WIDTH, 32, operand width; must be even; LO = WIDTH/2 bits per stage.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- in_valid  in  1  operands present
- in_ready  out  1  block accepts operands this cycle
- in_1  in  WIDTH  minuend
- in_2  in  WIDTH  subtrahend
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_diff  out  WIDTH  in_1 - in_2 modulo 2^WIDTH
- out_borrow  out  1  1 when in_1 < in_2 (unsigned)
- out_overflow  out  1  signed overflow; present only with SUB2_STAGE_OVF_EN

Behaviour:
- Reset (reset=0, async): all valid flags = 0 and all data registers = 0. While in reset: out_valid=0, out_diff=0, out_borrow=0, out_overflow=0. in_ready = 0 during reset and 1 on the first cycle after release.
- Stage 1 register (s1) holds:
  - s1_valid
  - lo difference: in_1[LO-1:0] - in_2[LO-1:0]
  - lo borrow
  - in_1/in_2 hi halves
- Stage 2 register (s2) holds:
  - s2_valid
  - full difference: {hi diff including lo borrow, lo diff}
  - borrow out of the hi half
  - (optional) overflow
- Outputs are driven directly from s2, registered; no combinational path from in_* data to out_*.
- Enables:
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1 (combinational from out_ready, by design; no skid buffer)
- Transfers:
  - Input transfer when in_valid && in_ready: s1 loads, s1_valid <= 1.
  - When adv1 && !in_valid: s1_valid <= 0.
  - When adv2: s2 loads from s1 and s2_valid <= s1_valid.
  - Data registers may load on bubbles; only the valid flags matter.
- Latency: 2 cycles from input transfer to out_valid with out_ready held 1. Throughput 1 result/cycle.
- Stall: out_valid && !out_ready holds s2 stable (data and flags unchanged). s1 holds if full, and in_ready=0 once both stages are full. Capacity is 2 in-flight results. No loss, no duplication, order preserved.
- Simultaneous events:
  - Pop from s2 and push into s1 in the same cycle is legal at full rate.
  - With both stages full and out_ready=1, in_ready=1 in that same cycle.
- Arithmetic:
  - out_borrow = 1 iff in_1 < in_2 unsigned.
  - out_diff wraps modulo 2^WIDTH.
  - Equal operands give diff 0, borrow 0.
- Reset mid-operation: all in-flight results are discarded immediately; nothing emerges after release.
- in_valid while in_ready=0: operands are ignored. Upstream must hold them.

Optional Feature:
- Macro SUB2_STAGE_OVF_EN.
- Defined:
  - out_overflow port exists.
  - out_overflow = (in_1[MSB] != in_2[MSB]) && (out_diff[MSB] != in_1[MSB]), i.e. two's-complement signed overflow.
  - Registered in s2 with the result; reset 0; held during stalls.
- Undefined: the port and its register are absent, and the remaining behaviour is identical.

Test Plan:
- Basic: in_1=9273, in_2=3827, out_ready=1 -> 2 cycles later out_valid=1, out_diff=5446, out_borrow=0.
- Borrow chain across halves: 0x00010000 - 0x00000001 -> 0x0000FFFF, borrow 0. Then 0 - 1 -> 0xFFFFFFFF, borrow 1. Then 0xFFFF0000 - 0xFFFF0000 -> 0, borrow 0.
- Streaming: back-to-back pairs (200,100), (13442,10042), (0,9253) with out_ready=1 -> results 100, 3400, 0xFFFFDBDB (borrow 1) on consecutive cycles starting 2 cycles after the first accept.
- Backpressure: out_ready=0 while 4 pairs are offered -> in_ready drops after 2 accepts and out_diff is frozen. Release out_ready -> all 4 differences emerge in order, none lost or duplicated.
- Reset mid-flight: assert reset with 2 results in flight -> out_valid=0 and out_diff=0 immediately (async). After release, no stale result appears and in_ready=1.
- With SUB2_STAGE_OVF_EN: 0x80000000 - 0x00000001 -> diff 0x7FFFFFFF, overflow 1, borrow 0. Then 0x7FFFFFFF - 0xFFFFFFFF -> diff 0x80000000, overflow 1, borrow 1. Then 5 - 3 -> overflow 0.
